// File: rtl/romix_scratchpad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : romix_scratchpad_ctrl
// Brief    : ROMix sequencer that drives the scratchpad RAM. In the fill phase
//            it stores each X into V[i] and forwards X to BlockMix. In the mix
//            phase it reads V[Integerify(X) mod N], XORs the entry into X and
//            forwards the result. It returns the final X after 2N iterations.
// Revision : 1.0 - initial release
// ============================================================================
module romix_scratchpad_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 1024,
  parameter int DEPTH      = 1024   // must equal 2**ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_x_valid,
  input  logic [DATA_WIDTH-1:0] i_x_data,
  output logic                  o_x_ready,
  output logic                  o_y_valid,
  output logic [DATA_WIDTH-1:0] o_y_data,
  input  logic                  i_y_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_done,
  output logic                  o_busy
);

  // Integerify takes the first 32-bit word of the last 64-byte sub-block.
  // Keeping only ADDR_WIDTH bits of it performs the mod N.
  localparam int                    C_IDX_LO   = DATA_WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] C_CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL_WAIT  = 3'd1,
    FILL_SEND  = 3'd2,
    MIX_WAIT   = 3'd3,
    MIX_RD1    = 3'd4,
    MIX_RD2    = 3'd5,
    MIX_SEND   = 3'd6,
    FINAL_WAIT = 3'd7
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic                  x_ready_q;
  logic                  y_valid_q;
  logic [DATA_WIDTH-1:0] y_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_write_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  done_q;
  logic                  busy_q;

  logic w_x_accept;
  logic w_y_xfer;

  assign w_x_accept = x_ready_q & i_x_valid;
  assign w_y_xfer   = y_valid_q & i_y_ready;

  // Sequencer: every output is a register updated together with the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      x_ready_q   <= 1'b0;
      y_valid_q   <= 1'b0;
      y_data_q    <= '0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Single-cycle strobes fall back unless a state re-asserts them.
      done_q      <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            cnt_q     <= '0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (w_x_accept) begin
            mem_addr_q  <= cnt_q;
            mem_write_q <= 1'b1;
            mem_wdata_q <= i_x_data;
            y_data_q    <= i_x_data;
            y_valid_q   <= 1'b1;
            x_ready_q   <= 1'b0;
            state_q     <= FILL_SEND;
          end
        end
        FILL_SEND: begin
          if (w_y_xfer) begin
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            if (cnt_q == C_CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= MIX_WAIT;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= FILL_WAIT;
            end
          end
        end
        MIX_WAIT: begin
          if (w_x_accept) begin
            x_q        <= i_x_data;
            mem_addr_q <= i_x_data[C_IDX_LO +: ADDR_WIDTH];
            x_ready_q  <= 1'b0;
            state_q    <= MIX_RD1;
          end
        end
        MIX_RD1: begin
          // The RAM samples o_mem_addr at the end of this cycle.
          state_q <= MIX_RD2;
        end
        MIX_RD2: begin
          y_data_q  <= x_q ^ i_mem_rdata;
          y_valid_q <= 1'b1;
          state_q   <= MIX_SEND;
        end
        MIX_SEND: begin
          if (w_y_xfer) begin
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            if (cnt_q == C_CNT_LAST) begin
              state_q <= FINAL_WAIT;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= MIX_WAIT;
            end
          end
        end
        FINAL_WAIT: begin
          if (w_x_accept) begin
            res_data_q <= i_x_data;
            done_q     <= 1'b1;
            x_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          x_ready_q <= 1'b0;
          y_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign o_x_ready   = x_ready_q;
  assign o_y_valid   = y_valid_q;
  assign o_y_data    = y_data_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_write = mem_write_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_res_data  = res_data_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_romix_scratchpad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_romix_scratchpad_ctrl
// Brief    : Directed bench for romix_scratchpad_ctrl at N=4 with a behavioural
//            scratchpad RAM, an expected-output queue and a golden ROMix model
//            (BlockMix stubbed as +1 on every 32-bit word).
// Revision : 1.0 - initial release
// ============================================================================
module tb_romix_scratchpad_ctrl;

  localparam int AW = 2;
  localparam int DW = 1024;
  localparam int N  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_x_valid = 1'b0;
  logic [DW-1:0] i_x_data = '0;
  logic          o_x_ready;
  logic          o_y_valid;
  logic [DW-1:0] o_y_data;
  logic          i_y_ready = 1'b1;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_write;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic [DW-1:0] o_res_data;
  logic          o_done;
  logic          o_busy;

  romix_scratchpad_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (N)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_x_valid  (i_x_valid),
    .i_x_data   (i_x_data),
    .o_x_ready  (o_x_ready),
    .o_y_valid  (o_y_valid),
    .o_y_data   (o_y_data),
    .i_y_ready  (i_y_ready),
    .o_mem_addr (o_mem_addr),
    .o_mem_write(o_mem_write),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .o_res_data (o_res_data),
    .o_done     (o_done),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous-read scratchpad: data appears one cycle after the address.
  logic [DW-1:0] ram [N];
  always @(posedge i_clk) begin
    if (o_mem_write) ram[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= ram[o_mem_addr];
  end

  // Event counters sampled mid-cycle, away from the active edge.
  int wr_cnt = 0;
  int y_cnt = 0;
  int done_cnt = 0;
  always @(negedge i_clk) begin
    if (o_mem_write) wr_cnt++;
    if (o_y_valid && i_y_ready) y_cnt++;
    if (o_done) done_cnt++;
  end

  int n_pass = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] vmodel [N];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b required=%b", tag, obs, exp);
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h required=%h", tag, obs, exp);
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed(low128)=%h required(low128)=%h", tag, obs[127:0], exp[127:0]);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] stub(input logic [DW-1:0] y);
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = y[w*32 +: 32] + 32'd1;
    return r;
  endfunction

  // Present X and return one cycle after the accepting edge.
  task automatic accept_x(input logic [DW-1:0] x);
    int n;
    n = 0;
    i_x_valid = 1'b1;
    i_x_data  = x;
    while (!o_x_ready && n < 50) begin
      tick();
      n++;
    end
    chk1("x_ready_wait", o_x_ready, 1'b1);
    tick();
    i_x_valid = 1'b0;
  endtask

  task automatic hold_y(input logic [DW-1:0] e);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        i_start   = 1'b1;
        i_x_valid = 1'b1;
        i_x_data  = ~e;
      end
      tick();
      i_start   = 1'b0;
      i_x_valid = 1'b0;
      chk1("bp_y_valid", o_y_valid, 1'b1);
      chkd("bp_y_data", o_y_data, e);
      chk1("bp_x_ready", o_x_ready, 1'b0);
      chk1("bp_mem_write", o_mem_write, 1'b0);
    end
    i_y_ready = 1'b1;
    tick();
  endtask

  task automatic start_run();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk1("start_busy", o_busy, 1'b1);
    chk1("start_x_ready", o_x_ready, 1'b1);
  endtask

  task automatic fill_step(input logic [DW-1:0] x, input logic [AW-1:0] addr, input bit bp);
    logic [DW-1:0] e;
    vmodel[addr] = x;
    exp_q.push_back(x);
    if (bp) i_y_ready = 1'b0;
    accept_x(x);
    e = exp_q.pop_front();
    chk1("fill_we", o_mem_write, 1'b1);
    chka("fill_addr", o_mem_addr, addr);
    chkd("fill_wdata", o_mem_wdata, x);
    chk1("fill_y_valid", o_y_valid, 1'b1);
    chkd("fill_y_data", o_y_data, e);
    if (bp) hold_y(e);
    else tick();
    chk1("fill_y_drop", o_y_valid, 1'b0);
    chk1("fill_we_drop", o_mem_write, 1'b0);
  endtask

  task automatic mix_step(input logic [DW-1:0] x, input logic [AW-1:0] idx, input bit bp, input bit spur);
    logic [DW-1:0] e;
    exp_q.push_back(x ^ vmodel[idx]);
    if (bp) i_y_ready = 1'b0;
    accept_x(x);
    chka("mix_addr", o_mem_addr, idx);
    chk1("mix_we", o_mem_write, 1'b0);
    chk1("mix_y_c1", o_y_valid, 1'b0);
    if (spur) begin
      i_start   = 1'b1;
      i_x_valid = 1'b1;
      i_x_data  = ~x;
    end
    tick();
    i_start   = 1'b0;
    i_x_valid = 1'b0;
    chk1("mix_y_c2", o_y_valid, 1'b0);
    chk1("mix_x_ready_c2", o_x_ready, 1'b0);
    tick();
    e = exp_q.pop_front();
    chk1("mix_y_valid", o_y_valid, 1'b1);
    chkd("mix_y_data", o_y_data, e);
    if (bp) hold_y(e);
    else tick();
    chk1("mix_y_drop", o_y_valid, 1'b0);
  endtask

  task automatic final_step(input logic [DW-1:0] x);
    accept_x(x);
    chk1("done_pulse", o_done, 1'b1);
    chkd("res_data", o_res_data, x);
    chk1("busy_fall", o_busy, 1'b0);
    chk1("final_x_ready", o_x_ready, 1'b0);
    tick();
    chk1("done_fall", o_done, 1'b0);
    chkd("res_hold", o_res_data, x);
  endtask

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] xs [2*N+1];
    logic [DW-1:0] y;
    logic [AW-1:0] js [N];
    int wr0, y0, d0;

    // Reset state.
    tick();
    tick();
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_x_ready", o_x_ready, 1'b0);
    chk1("rst_y_valid", o_y_valid, 1'b0);
    chk1("rst_mem_write", o_mem_write, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chkd("rst_res", o_res_data, '0);
    i_rst = 1'b0;
    tick();

    // Directed run: fill with 0x11..0x44, then indexed mix reads.
    wr0 = wr_cnt;
    y0  = y_cnt;
    start_run();
    for (int i = 0; i < N; i++) begin
      x = '0;
      x[7:0] = 8'h11 * 8'(i + 1);
      fill_step(x, AW'(i), i == 1);
    end
    x = rnd(); x[513:512] = 2'b10;
    mix_step(x, 2'd2, 1'b0, 1'b0);
    x = rnd(); x[513:512] = 2'b00;
    mix_step(x, 2'd0, 1'b0, 1'b1);
    x = rnd(); x[513:512] = 2'b11;
    mix_step(x, 2'd3, 1'b1, 1'b0);
    x = rnd(); x[513:512] = 2'b01;
    mix_step(x, 2'd1, 1'b0, 1'b0);
    final_step(rnd());
    chki("dir_writes", wr_cnt - wr0, N);
    chki("dir_y_xfers", y_cnt - y0, 2 * N);

    // Asynchronous reset while the controller sits in MIX_RD1.
    start_run();
    for (int i = 0; i < N; i++) fill_step(rnd(), AW'(i), 1'b0);
    accept_x(rnd());
    i_rst = 1'b1;
    #1;
    chk1("arst_busy", o_busy, 1'b0);
    chk1("arst_x_ready", o_x_ready, 1'b0);
    chk1("arst_y_valid", o_y_valid, 1'b0);
    chk1("arst_mem_write", o_mem_write, 1'b0);
    chka("arst_addr", o_mem_addr, '0);
    chkd("arst_y_data", o_y_data, '0);
    chkd("arst_res", o_res_data, '0);
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    chk1("arst_idle", o_busy, 1'b0);

    // Golden ROMix run with a +1-per-word BlockMix stub.
    xs[0] = rnd();
    for (int i = 0; i < N; i++) begin
      vmodel[i] = xs[i];
      xs[i+1] = stub(xs[i]);
    end
    for (int i = 0; i < N; i++) begin
      js[i] = xs[N+i][513:512];
      y = xs[N+i] ^ vmodel[js[i]];
      xs[N+i+1] = stub(y);
    end
    wr0 = wr_cnt;
    y0  = y_cnt;
    d0  = done_cnt;
    start_run();
    for (int i = 0; i < N; i++) fill_step(xs[i], AW'(i), 1'b0);
    for (int i = 0; i < N; i++) mix_step(xs[N+i], js[i], 1'b0, 1'b0);
    final_step(xs[2*N]);
    chki("gold_writes", wr_cnt - wr0, N);
    chki("gold_y_xfers", y_cnt - y0, 2 * N);
    chki("gold_done_count", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
